muldiv_seq: RTL
===============

Name: muldiv_seq

Overview:
Cycle sequencer and operand/writeback stage placed directly upstream of muldiv_top. It accepts one decoded MUL/DIV instruction from the execute stage and latches rs1, rs2, info and rd. It then drives muldiv_top from those latches and generates the pc_cycle count muldiv_top relies on. When the result is ready it presents it on a valid/ready writeback port to the register file, stalling the pipeline until then.

Parameters:
MUL_LAST, 17, final pc_cycle value of a multiply (result readable the following cycle)
DIV_LAST, 34, final pc_cycle value of a divide; equals the div fix cycle (6'b100010)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ex_i_valid  in  1  execute stage offers a muldiv instruction
ex_o_ready  out  1  sequencer can accept (IDLE)
ex_i_rs1  in  XLEN  operand 1
ex_i_rs2  in  XLEN  operand 2
ex_i_info  in  DECINFO_MULDIV_WIDTH  one-hot decoded muldiv info
ex_i_rd  in  5  destination register index
ex_i_flush  in  1  kill in-flight operation
pipe_o_stall  out  1  hold upstream pipeline
muldiv_o_rs1  out  XLEN  latched rs1 to muldiv_top
muldiv_o_rs2  out  XLEN  latched rs2 to muldiv_top
muldiv_o_info  out  DECINFO_MULDIV_WIDTH  latched info; zero when not RUN/DONE
pc_cycle  out  MAX_DELAY_WIDTH  cycle count to muldiv_top
muldiv_i_illegal  in  1  divide-by-zero flag from muldiv_top
muldiv_i_res  in  XLEN  muldiv_wbck_res from muldiv_top
wbck_o_valid  out  1  writeback request
wbck_i_ready  in  1  register file accepts
wbck_o_rd  out  5  destination index
wbck_o_data  out  XLEN  result

Behaviour:
- clk is the only clock. rst_n is asynchronous, active-low. Reset forces state IDLE and clears every register. All outputs are 0 at reset, except ex_o_ready=1.
- States: IDLE, RUN, DONE. The state and latches are only ever cleared by rst_n or flush.
- IDLE:
  - ex_o_ready=1, pc_cycle=0, muldiv_o_info=0, wbck_o_valid=0.
  - Accept occurs when ex_i_valid=1 and ex_i_info is nonzero. On accept: latch rs1, rs2, info and rd; go to RUN; pc_cycle becomes 1 next cycle.
  - ex_i_valid with zero info is ignored.
- RUN:
  - pc_cycle increments by 1 each cycle. muldiv_o_info equals the latched info, so the start cycle is pc_cycle==1.
  - last = MUL_LAST if latched info is a mul type, else DIV_LAST. At pc_cycle==last, go to DONE next cycle and freeze pc_cycle at last+1. muldiv_o_info stays latched, so muldiv_top output remains stable.
  - Early exit: if the op is div-type and muldiv_i_illegal=1 at pc_cycle==1, go to DONE next cycle with the override flag set.
- DONE:
  - wbck_o_valid=1, wbck_o_rd = latched rd.
  - wbck_o_data = muldiv_i_res, unless the override flag is set: then DIV/DIVU give all-ones and REM/REMU give latched rs1.
  - When wbck_i_ready=1, go to IDLE next cycle. Otherwise hold all outputs stable.
- pipe_o_stall = (state != IDLE) or (IDLE and accept). The upstream stage holds until writeback completes.
- ex_i_flush, in any non-IDLE state: go to IDLE next cycle. wbck_o_valid is forced low combinationally in that cycle. Flush wins over a simultaneous wbck_i_ready, so no write occurs.
- ex_i_flush in IDLE: suppresses accept.
- Reset mid-operation: immediate IDLE, no writeback, latches cleared.
- pc_cycle never wraps; its maximum value is DIV_LAST+1 = 35, which fits in 6 bits.
- Latency, accept to wbck_o_valid: MUL_LAST+1 cycles for mul (18), DIV_LAST+1 for div (35), 2 for divide-by-zero.

Decomposition:
- Shared defines header: state encodings, MUL_LAST/DIV_LAST defaults, and the DECINFO_MULDIV_* bit indices (already shared).
- XLEN, MAX_DELAY_WIDTH and DECINFO_MULDIV_WIDTH come from the existing defines.
- No sub-module. A single FSM plus latches is natural.
- A top-level wrapper instantiating muldiv_seq and muldiv_top is optional.

Test Plan:
- MUL, rs1=7, rs2=6, wbck_i_ready=1 -> pc_cycle 1..17, wbck_o_valid at cycle 18 after accept, data=42, rd echoed, then IDLE.
- DIVU, rs1=100, rs2=7 -> wbck at cycle 35 with data 14; REMU on the same operands -> data 2. pipe_o_stall high throughout.
- DIV, rs1=0x80000005, rs2=0 -> illegal at pc_cycle 1, wbck at cycle 2 with data 0xFFFFFFFF; REM, same operands -> data 0x80000005.
- MULH, rs1=0x80000000, rs2=0x80000000, wbck_i_ready held low 5 cycles in DONE -> data 0x40000000 stable and valid held throughout; one write on the ready cycle.
- DIV in flight, ex_i_flush at pc_cycle 20 -> IDLE next cycle, no wbck_o_valid, ex_o_ready=1. Flush coinciding with wbck_i_ready in DONE -> no write.
- rst_n asserted at pc_cycle 10 of a DIV -> all outputs 0 immediately (ex_o_ready=1). A new MUL accepted after release completes normally.

Source files
------------

// File: rtl/muldiv_seq_pkg.sv
// Shared widths, decoded-info bit positions and sequencer state encoding for
// the muldiv sequencer.
package muldiv_seq_pkg;

  localparam int XLEN                 = 32;
  localparam int MAX_DELAY_WIDTH      = 6;
  localparam int DECINFO_MULDIV_WIDTH = 8;

  localparam int DECINFO_MULDIV_MUL    = 0;
  localparam int DECINFO_MULDIV_MULH   = 1;
  localparam int DECINFO_MULDIV_MULHSU = 2;
  localparam int DECINFO_MULDIV_MULHU  = 3;
  localparam int DECINFO_MULDIV_DIV    = 4;
  localparam int DECINFO_MULDIV_DIVU   = 5;
  localparam int DECINFO_MULDIV_REM    = 6;
  localparam int DECINFO_MULDIV_REMU   = 7;

  localparam int MUL_LAST_DEFAULT = 17;
  localparam int DIV_LAST_DEFAULT = 34;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

  function automatic logic info_is_mul(input logic [DECINFO_MULDIV_WIDTH-1:0] info);
    return info[DECINFO_MULDIV_MUL] | info[DECINFO_MULDIV_MULH] |
           info[DECINFO_MULDIV_MULHSU] | info[DECINFO_MULDIV_MULHU];
  endfunction

  function automatic logic info_is_rem(input logic [DECINFO_MULDIV_WIDTH-1:0] info);
    return info[DECINFO_MULDIV_REM] | info[DECINFO_MULDIV_REMU];
  endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// Execute-side, muldiv_top-side and writeback signals of the muldiv sequencer.
// The sequencer uses the slave modport; its surroundings use master.
interface muldiv_seq_if;
  import muldiv_seq_pkg::*;

  logic                            ex_i_valid;
  logic                            ex_o_ready;
  logic [XLEN-1:0]                 ex_i_rs1;
  logic [XLEN-1:0]                 ex_i_rs2;
  logic [DECINFO_MULDIV_WIDTH-1:0] ex_i_info;
  logic [4:0]                      ex_i_rd;
  logic                            ex_i_flush;
  logic                            pipe_o_stall;
  logic [XLEN-1:0]                 muldiv_o_rs1;
  logic [XLEN-1:0]                 muldiv_o_rs2;
  logic [DECINFO_MULDIV_WIDTH-1:0] muldiv_o_info;
  logic [MAX_DELAY_WIDTH-1:0]      pc_cycle;
  logic                            muldiv_i_illegal;
  logic [XLEN-1:0]                 muldiv_i_res;
  logic                            wbck_o_valid;
  logic                            wbck_i_ready;
  logic [4:0]                      wbck_o_rd;
  logic [XLEN-1:0]                 wbck_o_data;

  modport slave (
    input  ex_i_valid, ex_i_rs1, ex_i_rs2, ex_i_info, ex_i_rd, ex_i_flush,
    input  muldiv_i_illegal, muldiv_i_res, wbck_i_ready,
    output ex_o_ready, pipe_o_stall, muldiv_o_rs1, muldiv_o_rs2, muldiv_o_info,
    output pc_cycle, wbck_o_valid, wbck_o_rd, wbck_o_data
  );

  modport master (
    output ex_i_valid, ex_i_rs1, ex_i_rs2, ex_i_info, ex_i_rd, ex_i_flush,
    output muldiv_i_illegal, muldiv_i_res, wbck_i_ready,
    input  ex_o_ready, pipe_o_stall, muldiv_o_rs1, muldiv_o_rs2, muldiv_o_info,
    input  pc_cycle, wbck_o_valid, wbck_o_rd, wbck_o_data
  );

endinterface

// File: rtl/muldiv_seq.sv
// Operand latch, pc_cycle sequencer and writeback stage in front of muldiv_top.
// One instruction in flight; the upstream pipeline stalls until it is written back.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int MUL_LAST = MUL_LAST_DEFAULT,
  parameter int DIV_LAST = DIV_LAST_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  muldiv_seq_if.slave  bus
);

  seq_state_e                      r_state;
  logic [XLEN-1:0]                 r_rs1;
  logic [XLEN-1:0]                 r_rs2;
  logic [DECINFO_MULDIV_WIDTH-1:0] r_info;
  logic [4:0]                      r_rd;
  logic [MAX_DELAY_WIDTH-1:0]      r_pc;
  logic                            r_override;

  logic                            w_accept;
  logic                            w_kill;
  logic [MAX_DELAY_WIDTH-1:0]      w_last;
  logic [XLEN-1:0]                 w_done_data;

  assign w_accept = (r_state == ST_IDLE) && bus.ex_i_valid && (|bus.ex_i_info) && !bus.ex_i_flush;
  assign w_kill   = (r_state != ST_IDLE) && bus.ex_i_flush;
  assign w_last   = info_is_mul(r_info) ? MAX_DELAY_WIDTH'(MUL_LAST) : MAX_DELAY_WIDTH'(DIV_LAST);

  // NOTE: every state register is assigned with <= so all of them update from
  // the same pre-edge values; a blocking write here would leak into later reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_info     <= '0;
      r_rd       <= '0;
      r_pc       <= '0;
      r_override <= 1'b0;
    end else if (w_kill) begin
      r_state    <= ST_IDLE;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_info     <= '0;
      r_rd       <= '0;
      r_pc       <= '0;
      r_override <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_rs1      <= bus.ex_i_rs1;
            r_rs2      <= bus.ex_i_rs2;
            r_info     <= bus.ex_i_info;
            r_rd       <= bus.ex_i_rd;
            r_pc       <= MAX_DELAY_WIDTH'(1);
            r_override <= 1'b0;
            r_state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_pc <= r_pc + MAX_DELAY_WIDTH'(1);
          // A divide by zero is flagged on the start cycle; skip the long divide.
          if (!info_is_mul(r_info) && (r_pc == MAX_DELAY_WIDTH'(1)) && bus.muldiv_i_illegal) begin
            r_override <= 1'b1;
            r_state    <= ST_DONE;
          end else if (r_pc == w_last) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.wbck_i_ready) begin
            r_pc    <= '0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: default assignment first so no path through this block infers a latch.
  always_comb begin
    w_done_data = bus.muldiv_i_res;
    if (r_override) begin
      w_done_data = info_is_rem(r_info) ? r_rs1 : {XLEN{1'b1}};
    end
  end

  assign bus.ex_o_ready    = (r_state == ST_IDLE);
  assign bus.pipe_o_stall  = (r_state != ST_IDLE) || w_accept;
  assign bus.muldiv_o_rs1  = r_rs1;
  assign bus.muldiv_o_rs2  = r_rs2;
  assign bus.muldiv_o_info = (r_state != ST_IDLE) ? r_info : '0;
  assign bus.pc_cycle      = r_pc;
  assign bus.wbck_o_valid  = (r_state == ST_DONE) && !bus.ex_i_flush;
  assign bus.wbck_o_rd     = (r_state == ST_DONE) ? r_rd : 5'd0;
  assign bus.wbck_o_data   = (r_state == ST_DONE) ? w_done_data : '0;

endmodule
